vram_pattern_gen: RTL and testbench

- Parametrised test-pattern engine driving port B of the character/attribute video RAM, for bring-up of the VGA text pipeline.
- On a start request it sweeps a programmable number of words at a programmable pace, writing one of four selectable patterns.
- An optional read-back pass compares RAM contents against the expected pattern and reports the first mismatching address.
- Replaces the fixed-rate, free-running, always-writing pattern writer: it adds start/busy/done handshake, reset, mode select, depth limit and verification.

---
 rtl/vram_pattern_gen_if.sv | 32 +++
 rtl/vram_pattern_gen.sv | 175 +++++++++++++++++
 tb/tb_vram_pattern_gen.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/vram_pattern_gen_if.sv
// Control and RAM port B bundle for the VRAM pattern engine.
// slave is the engine side, master is the host plus RAM side.
interface vram_pattern_gen_if #(
  parameter int ADDR_W = 12,
  parameter int DIV_W  = 16
) ();
  logic              start;
  logic [1:0]        mode;
  logic [7:0]        seed;
  logic [DIV_W-1:0]  div;
  logic              verify;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] err_addr;
  logic [ADDR_W-1:0] addr_b;
  logic [31:0]       data_b;
  logic              we_b;
  logic [31:0]       q_b;

  modport slave (
    input  start, mode, seed, div, verify, q_b,
    output busy, done, err, err_addr,
    output addr_b, data_b, we_b
  );

  modport master (
    output start, mode, seed, div, verify, q_b,
    input  busy, done, err, err_addr,
    input  addr_b, data_b, we_b
  );
endinterface

// File: rtl/vram_pattern_gen.sv
// VRAM port B test-pattern engine: paced write sweep with
// optional read-back verify and first-mismatch capture.
module vram_pattern_gen #(
  parameter int          ADDR_W = 12,
  parameter int          DEPTH  = 4096,
  parameter int          DIV_W  = 16,
  parameter logic [5:0]  ATTR_A = 6'b111010,
  parameter logic [9:0]  ATTR_B = 10'b1010010000
) (
  input logic          clk,
  input logic          rst_n,
  vram_pattern_gen_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, WR, GAP, RD, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [1:0]        mode_l;
  logic [7:0]        seed_l;
  logic [DIV_W-1:0]  div_l;
  logic              verify_l;
  logic [ADDR_W-1:0] a;
  logic [7:0]        v;
  logic [DIV_W-1:0]  cnt;
  logic [31:0]       exp_w;
  logic [ADDR_W-1:0] exp_a;
  logic              cmp_vld;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] err_addr;
  logic [ADDR_W-1:0] addr_b;
  logic [31:0]       data_b;
  logic              we_b;

  function automatic logic [31:0] pat(
    input logic [1:0]        m,
    input logic [ADDR_W-1:0] aa,
    input logic [7:0]        vv,
    input logic [7:0]        sd
  );
    logic [31:0] w;
    unique case (m)
      2'd0:    w = {vv, ATTR_A, vv + 8'd1, ATTR_B};
      2'd1:    w = {4{sd}};
      2'd2:    w = 32'(aa);
      default: w = aa[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
    endcase
    return w;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mode_l   <= '0;
      seed_l   <= '0;
      div_l    <= '0;
      verify_l <= 1'b0;
      a        <= '0;
      v        <= '0;
      cnt      <= '0;
      exp_w    <= '0;
      exp_a    <= '0;
      cmp_vld  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_addr <= '0;
      addr_b   <= '0;
      data_b   <= '0;
      we_b     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            mode_l   <= bus.mode;
            seed_l   <= bus.seed;
            div_l    <= bus.div;
            verify_l <= bus.verify;
            a        <= '0;
            v        <= bus.seed;
            err      <= 1'b0;
            err_addr <= '0;
            busy     <= 1'b1;
            we_b     <= 1'b1;
            addr_b   <= '0;
            data_b   <= pat(bus.mode, '0,
                            bus.seed, bus.seed);
            state    <= WR;
          end
        end
        WR: begin
          we_b <= 1'b0;
          if (a == LAST) begin
            a <= '0;
            v <= seed_l;
            if (verify_l) begin
              addr_b  <= '0;
              cmp_vld <= 1'b0;
              state   <= RD;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end else begin
            a <= a + 1'b1;
            v <= v + 8'd1;
            if (div_l != '0) begin
              cnt   <= div_l;
              state <= GAP;
            end else begin
              we_b   <= 1'b1;
              addr_b <= a + 1'b1;
              data_b <= pat(mode_l, a + 1'b1,
                            v + 8'd1, seed_l);
            end
          end
        end
        GAP: begin
          if (cnt == DIV_W'(1)) begin
            we_b   <= 1'b1;
            addr_b <= a;
            data_b <= pat(mode_l, a, v, seed_l);
            state  <= WR;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD: begin
          // q_b now holds the word for the address issued last cycle
          if (cmp_vld &&
              (bus.q_b != exp_w || exp_a == LAST)) begin
            if (bus.q_b != exp_w) begin
              err      <= 1'b1;
              err_addr <= exp_a;
            end
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            exp_w   <= pat(mode_l, a, v, seed_l);
            exp_a   <= a;
            cmp_vld <= 1'b1;
            if (a != LAST) begin
              a      <= a + 1'b1;
              v      <= v + 8'd1;
              addr_b <= a + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.err      = err;
  assign bus.err_addr = err_addr;
  assign bus.addr_b   = addr_b;
  assign bus.data_b   = data_b;
  assign bus.we_b     = we_b;

endmodule

// File: tb/tb_vram_pattern_gen.sv
// Randomised sweep bench for vram_pattern_gen with a RAM model
// and a cycle-level expectation built from sweep parameters.
module tb_vram_pattern_gen;

  localparam int AW  = 12;
  localparam int DW  = 16;
  localparam int DEP = 8;
  localparam logic [5:0] AA = 6'b111010;
  localparam logic [9:0] AB = 10'b1010010000;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  bit   corrupt_on;
  int   corrupt_addr;
  logic [31:0] first_data;
  logic [31:0] mem [0:(1<<AW)-1];

  vram_pattern_gen_if #(.ADDR_W(AW), .DIV_W(DW)) bus ();

  vram_pattern_gen #(
    .ADDR_W(AW), .DEPTH(DEP), .DIV_W(DW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registered-read RAM; optionally flips bit 0 on one address
  always @(posedge clk) begin
    if (bus.we_b) mem[bus.addr_b] <= bus.data_b;
    bus.q_b <= mem[bus.addr_b] ^
      ((corrupt_on && int'(bus.addr_b) == corrupt_addr)
        ? 32'h1 : 32'h0);
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(
    input logic [1:0] m, input int k, input logic [7:0] s);
    logic [7:0] vv;
    vv = s + 8'(k);
    case (m)
      2'd0: return {vv, AA, vv + 8'd1, AB};
      2'd1: return {s, s, s, s};
      2'd2: return 32'(k);
      default: return (k % 2 == 1) ? 32'h5555_5555
                                   : 32'hAAAA_AAAA;
    endcase
  endfunction

  task automatic sweep(input logic [1:0] m,
                       input logic [7:0] s,
                       input int d, input bit vf,
                       input int bad);
    int l_t, r_t, done_t, k;
    bit e_err;
    int e_ea;
    corrupt_on   = (bad >= 0);
    corrupt_addr = bad;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mode   = m;
    bus.seed   = s;
    bus.div    = DW'(d);
    bus.verify = vf;
    l_t = (DEP - 1) * (d + 1);
    r_t = l_t + 1;
    e_err = vf && bad >= 0;
    e_ea  = e_err ? bad : 0;
    if (!vf)       done_t = l_t + 1;
    else if (e_err) done_t = r_t + bad + 2;
    else           done_t = r_t + DEP + 1;
    for (int t = 0; t <= done_t + 1; t++) begin
      @(negedge clk);
      if (t == 0) first_data = bus.data_b;
      check("ctl", {bus.busy, bus.done, bus.we_b, bus.err},
            {t < done_t, t == done_t,
             t <= l_t && t % (d + 1) == 0,
             e_err && t >= done_t});
      if (t <= l_t) begin
        k = t / (d + 1);
        check("wr_addr", bus.addr_b, k);
        check("wr_data", bus.data_b, ref_word(m, k, s));
      end else if (vf && t < done_t) begin
        k = (t - r_t < DEP - 1) ? t - r_t : DEP - 1;
        check("rd_addr", bus.addr_b, k);
        check("rd_data", bus.data_b,
              ref_word(m, DEP - 1, s));
      end
      if (t >= done_t)
        check("err_addr", bus.err_addr, e_ea);
      // junk on inputs: a sweep must ignore all of it
      bus.start  = (t <= done_t) &&
                   ($urandom_range(0, 3) == 0);
      bus.mode   = 2'($urandom);
      bus.seed   = 8'($urandom);
      bus.div    = DW'($urandom_range(0, 3));
      bus.verify = 1'($urandom);
    end
    bus.start = 1'b0;
  endtask

  task automatic reset_mid_sweep();
    corrupt_on = 1'b0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mode   = 2'($urandom);
    bus.seed   = 8'($urandom);
    bus.div    = DW'(3);
    bus.verify = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_pre_we", bus.we_b, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_ctl", {bus.busy, bus.done, bus.we_b, bus.err},
          4'b0000);
    check("rst_addr", bus.addr_b, 0);
    check("rst_data", bus.data_b, 0);
    check("rst_eaddr", bus.err_addr, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold", {bus.done, bus.we_b}, 2'b00);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    corrupt_on = 1'b0;
    corrupt_addr = -1;
    rst_n = 1'b0;
    bus.start  = 1'b0;
    bus.mode   = '0;
    bus.seed   = '0;
    bus.div    = '0;
    bus.verify = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_ctl",
            {bus.busy, bus.done, bus.we_b, bus.err}, 4'b0000);
      check("idle_ad", {bus.addr_b, bus.data_b}, 0);
    end

    sweep(2'd0, 8'hFE, 0, 1'b0, -1);
    check("char0", first_data,
          {8'hFE, 6'b111010, 8'hFF, 10'b1010010000});
    sweep(2'd3, 8'($urandom), 2, 1'b0, -1);
    sweep(2'd2, 8'($urandom), 0, 1'b1, -1);
    sweep(2'd2, 8'($urandom), 0, 1'b1, 5);
    sweep(2'd1, 8'($urandom), 1, 1'b1, DEP - 1);
    sweep(2'd0, 8'($urandom), 0, 1'b1, 0);
    reset_mid_sweep();
    sweep(2'($urandom), 8'($urandom), 1, 1'b1, -1);

    for (int n = 0; n < 12; n++) begin
      sweep(2'($urandom), 8'($urandom),
            $urandom_range(0, 3), 1'($urandom),
            ($urandom_range(0, 2) == 0)
              ? $urandom_range(0, DEP - 1) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
